// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: immediate formats, opcode match patterns
// and the hardwired zero-register index.
package legv8_pkg;

  typedef enum logic [2:0] {
    FMT_B,
    FMT_CB,
    FMT_D,
    FMT_I,
    FMT_R
  } imm_fmt_t;

  localparam logic [5:0] OP_B    = 6'b000101;
  localparam logic [5:0] OP_BL   = 6'b100101;
  localparam logic [6:0] OP_CB   = 7'b1011010;
  localparam logic [7:0] OP_D    = 8'hF8;
  localparam logic [2:0] OP_I    = 3'b100;

  localparam int ZERO_REG_IDX = 31;

endpackage

// File: rtl/imm_gen.sv
// Combinational LEGv8 immediate extractor: classifies the instruction format
// in priority order and produces the unshifted, WORD-wide extended immediate.
module imm_gen
  import legv8_pkg::*;
#(
  parameter int WORD = 64
) (
  input  logic [31:0]     inst,
  output imm_fmt_t        fmt,
  output logic [WORD-1:0] imm
);

  always_comb begin
    fmt = FMT_R;
    imm = WORD'(inst[15:10]);
    if (inst[31:26] == OP_B || inst[31:26] == OP_BL) begin
      fmt = FMT_B;
      imm = WORD'($signed(inst[25:0]));
    end else if (inst[31:25] == OP_CB) begin
      fmt = FMT_CB;
      imm = WORD'($signed(inst[23:5]));
    end else if (inst[31:24] == OP_D) begin
      fmt = FMT_D;
      imm = WORD'($signed(inst[20:12]));
    end else if (inst[28:26] == OP_I) begin
      fmt = FMT_I;
      imm = WORD'(inst[21:10]);
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined LEGv8 decode stage: register file (XZR hardwired), operand read,
// immediate extraction, ID/EX register with valid/ready and load-use stall.
// Optional write-through bypass of the write-back port: define ID_BYPASS_EN.
module id_stage_pipe
  import legv8_pkg::*;
#(
  parameter int WORD     = 64,
  parameter int REG_NUM  = 32,
  parameter int ZERO_REG = ZERO_REG_IDX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic            Reg2Loc,
  input  logic            MemRead,
  input  logic            w_en,
  input  logic [4:0]      w_reg,
  input  logic [WORD-1:0] w_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_r_data1,
  output logic [WORD-1:0] out_r_data2,
  output logic [WORD-1:0] out_ex_data,
  output logic [4:0]      out_rd,
  output logic            out_mem_read,
  output logic [31:0]     out_inst
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  logic [WORD-1:0] rf_q [REG_NUM];
  logic [WORD-1:0] rf_d [REG_NUM];

  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [WORD-1:0] rs1_val;
  logic [WORD-1:0] rs2_val;
  logic [WORD-1:0] imm;
  imm_fmt_t        fmt_unused;
  logic            hazard;
  logic            accept;

  logic            out_valid_q,    out_valid_d;
  logic [WORD-1:0] r_data1_q,      r_data1_d;
  logic [WORD-1:0] r_data2_q,      r_data2_d;
  logic [WORD-1:0] ex_data_q,      ex_data_d;
  logic [4:0]      rd_q,           rd_d;
  logic            mem_read_q,     mem_read_d;
  logic [31:0]     inst_q,         inst_d;

  imm_gen #(.WORD(WORD)) u_imm_gen (
    .inst (inst),
    .fmt  (fmt_unused),
    .imm  (imm)
  );

  // Bypass never applies to the zero register; it always reads as 0.
  function automatic logic [WORD-1:0] read_reg(input logic [4:0] idx);
    logic [WORD-1:0] val;
    val = rf_q[idx];
`ifdef ID_BYPASS_EN
    if (w_en && w_reg == idx) val = w_data;
`endif
    if (idx == ZR) val = '0;
    return val;
  endfunction

  always_comb begin
    rs1_idx = inst[9:5];
    rs2_idx = Reg2Loc ? inst[4:0] : inst[20:16];
    rs1_val = read_reg(rs1_idx);
    rs2_val = read_reg(rs2_idx);
  end

  always_comb begin
    rf_d = rf_q;
    if (w_en && w_reg != ZR) rf_d[w_reg] = w_data;
  end

  // A load still in ID/EX whose destination is a source here costs one bubble.
  always_comb begin
    hazard   = out_valid_q && mem_read_q && (rd_q != ZR) &&
               (rd_q == rs1_idx || rd_q == rs2_idx);
    in_ready = (!out_valid_q || out_ready) && !hazard;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    r_data1_d   = r_data1_q;
    r_data2_d   = r_data2_q;
    ex_data_d   = ex_data_q;
    rd_d        = rd_q;
    mem_read_d  = mem_read_q;
    inst_d      = inst_q;
    if (accept) begin
      out_valid_d = 1'b1;
      r_data1_d   = rs1_val;
      r_data2_d   = rs2_val;
      ex_data_d   = imm;
      rd_d        = inst[4:0];
      mem_read_d  = MemRead;
      inst_d      = inst;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) rf_q[i] <= '0;
      out_valid_q <= 1'b0;
      r_data1_q   <= '0;
      r_data2_q   <= '0;
      ex_data_q   <= '0;
      rd_q        <= '0;
      mem_read_q  <= 1'b0;
      inst_q      <= '0;
    end else begin
      rf_q        <= rf_d;
      out_valid_q <= out_valid_d;
      r_data1_q   <= r_data1_d;
      r_data2_q   <= r_data2_d;
      ex_data_q   <= ex_data_d;
      rd_q        <= rd_d;
      mem_read_q  <= mem_read_d;
      inst_q      <= inst_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_r_data1  = r_data1_q;
  assign out_r_data2  = r_data2_q;
  assign out_ex_data  = ex_data_q;
  assign out_rd       = rd_q;
  assign out_mem_read = mem_read_q;
  assign out_inst     = inst_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe: decode formats, register
// file write/read, load-use stall, backpressure, zero register and reset.
module tb_id_stage_pipe;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic        inReady;
   logic [31:0] inst;
   logic        reg2Loc;
   logic        memRead;
   logic        wEn;
   logic [4:0]  wReg;
   logic [63:0] wData;
   logic        outValid;
   logic        outReady;
   logic [63:0] outRData1;
   logic [63:0] outRData2;
   logic [63:0] outExData;
   logic [4:0]  outRd;
   logic        outMemRead;
   logic [31:0] outInst;

   int vectors;
   int miscompares;

   localparam logic [31:0] LDUR_X9   = 32'hF84402C9;
   localparam logic [31:0] LDUR_XZR  = 32'hF84402DF;
   localparam logic [31:0] CBZ_X11   = 32'hB4FFFF6B;
   localparam logic [31:0] B_M55     = 32'h17FFFFC9;
   localparam logic [31:0] ADDI_X1   = 32'h91048C41;
   localparam logic [31:0] ADD_SH5   = 32'h8B09166A;
   localparam logic [31:0] ADD_X9    = 32'h8B09026A;
   localparam logic [31:0] ADD_XZR   = 32'h8B1F026A;
   localparam logic [31:0] ADD_RNZR  = 32'h8B0903EA;
   localparam logic [31:0] ORR_X9    = 32'hAA150149;

   id_stage_pipe dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (inValid),
      .in_ready     (inReady),
      .inst         (inst),
      .Reg2Loc      (reg2Loc),
      .MemRead      (memRead),
      .w_en         (wEn),
      .w_reg        (wReg),
      .w_data       (wData),
      .out_valid    (outValid),
      .out_ready    (outReady),
      .out_r_data1  (outRData1),
      .out_r_data2  (outRData2),
      .out_ex_data  (outExData),
      .out_rd       (outRd),
      .out_mem_read (outMemRead),
      .out_inst     (outInst)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle so registered outputs are stable
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction to the decode stage
   task automatic applyStimulus(input logic v, input logic [31:0] i,
                                input logic r2l, input logic mr);
      inValid = v;
      inst    = i;
      reg2Loc = r2l;
      memRead = mr;
      #1;
   endtask

   // Single comparison point: counts every vector and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Directed scenario sequence
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst      = 1'b1;
      inValid  = 1'b0;
      inst     = '0;
      reg2Loc  = 1'b0;
      memRead  = 1'b0;
      wEn      = 1'b0;
      wReg     = '0;
      wData    = '0;
      outReady = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkOutput("rst_out_valid", 64'(outValid), 64'd0);
      checkOutput("rst_out_inst", 64'(outInst), 64'd0);
      checkOutput("rst_in_ready", 64'(inReady), 64'd1);

      wEn = 1'b1; wReg = 5'd9; wData = 64'd1;
      tick();
      wEn = 1'b0;

      applyStimulus(1'b1, LDUR_X9, 1'b1, 1'b1);
      checkOutput("ldur_in_ready", 64'(inReady), 64'd1);
      tick();
      checkOutput("ldur_valid", 64'(outValid), 64'd1);
      checkOutput("ldur_rdata1", outRData1, 64'd0);
      checkOutput("ldur_rdata2_x9", outRData2, 64'd1);
      checkOutput("ldur_imm", outExData, 64'd64);
      checkOutput("ldur_rd", 64'(outRd), 64'd9);
      checkOutput("ldur_memread", 64'(outMemRead), 64'd1);

      applyStimulus(1'b1, CBZ_X11, 1'b1, 1'b0);
      tick();
      checkOutput("cbz_rdata2", outRData2, 64'd0);
      checkOutput("cbz_imm", outExData, 64'hFFFFFFFFFFFFFFFB);
      checkOutput("cbz_rd", 64'(outRd), 64'd11);
      applyStimulus(1'b1, B_M55, 1'b0, 1'b0);
      tick();
      checkOutput("b_imm", outExData, 64'hFFFFFFFFFFFFFFC9);
      applyStimulus(1'b1, ADDI_X1, 1'b0, 1'b0);
      tick();
      checkOutput("addi_imm", outExData, 64'h123);
      applyStimulus(1'b1, ADD_SH5, 1'b0, 1'b0);
      tick();
      checkOutput("add_shamt", outExData, 64'd5);

      applyStimulus(1'b1, LDUR_X9, 1'b0, 1'b1);
      tick();
      checkOutput("ldur2_valid", 64'(outValid), 64'd1);
      applyStimulus(1'b1, ADD_X9, 1'b0, 1'b0);
      checkOutput("hazard_in_ready", 64'(inReady), 64'd0);
      tick();
      checkOutput("bubble_valid", 64'(outValid), 64'd0);
      checkOutput("post_bubble_ready", 64'(inReady), 64'd1);
      tick();
      checkOutput("add_after_stall", 64'(outInst), 64'(ADD_X9));
      checkOutput("add_after_stall_v", 64'(outValid), 64'd1);
      checkOutput("add_rdata2_x9", outRData2, 64'd1);
      checkOutput("add_rd", 64'(outRd), 64'd10);

      applyStimulus(1'b1, LDUR_XZR, 1'b0, 1'b1);
      tick();
      checkOutput("ldur_xzr_rd", 64'(outRd), 64'd31);
      applyStimulus(1'b1, ADD_XZR, 1'b0, 1'b0);
      checkOutput("xzr_no_stall", 64'(inReady), 64'd1);
      tick();
      checkOutput("add_xzr_issued", 64'(outInst), 64'(ADD_XZR));
      checkOutput("add_xzr_rdata2", outRData2, 64'd0);

      outReady = 1'b0;
      applyStimulus(1'b1, ADD_X9, 1'b0, 1'b0);
      checkOutput("bp_in_ready", 64'(inReady), 64'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput("bp_hold_inst", 64'(outInst), 64'(ADD_XZR));
         checkOutput("bp_hold_valid", 64'(outValid), 64'd1);
         checkOutput("bp_hold_ready", 64'(inReady), 64'd0);
      end
      outReady = 1'b1;
      #1;
      checkOutput("bp_release_ready", 64'(inReady), 64'd1);
      tick();
      checkOutput("bp_release_inst", 64'(outInst), 64'(ADD_X9));
      applyStimulus(1'b1, ORR_X9, 1'b0, 1'b0);
      tick();
      checkOutput("b2b_inst", 64'(outInst), 64'(ORR_X9));
      checkOutput("b2b_valid", 64'(outValid), 64'd1);

      wEn = 1'b1; wReg = 5'd10; wData = 64'd20;
      applyStimulus(1'b1, ORR_X9, 1'b0, 1'b0);
      tick();
`ifdef ID_BYPASS_EN
      checkOutput("same_cycle_wr", outRData1, 64'd20);
`else
      checkOutput("same_cycle_wr", outRData1, 64'd0);
`endif
      wReg = 5'd31; wData = 64'd55;
      applyStimulus(1'b1, ADD_RNZR, 1'b0, 1'b0);
      tick();
      checkOutput("xzr_wr_bypass", outRData1, 64'd0);
      wEn = 1'b0;
      tick();
      checkOutput("xzr_read", outRData1, 64'd0);
      applyStimulus(1'b1, ORR_X9, 1'b0, 1'b0);
      tick();
      checkOutput("x10_after_wr", outRData1, 64'd20);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checkOutput("midrst_valid", 64'(outValid), 64'd0);
      checkOutput("midrst_inst", 64'(outInst), 64'd0);
      checkOutput("midrst_ready", 64'(inReady), 64'd1);
      tick();
      checkOutput("midrst_x10", outRData1, 64'd0);
      checkOutput("midrst_accept", 64'(outValid), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
